// File: rtl/cmd_frame_rx.sv
// Receive-side parser for UART command frames: HDR0 HDR1 CMD LEN PAYLOAD[LEN] CHK.
// Define CMD_RX_ERR_CNT_EN to build the saturating error counter behind err_cnt.
module cmd_frame_rx #(
    parameter logic [7:0] HDR0        = 8'hEB,
    parameter logic [7:0] HDR1        = 8'h90,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 110592
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 rx_fifo_empty,
    output logic                 rx_fifo_ren,
    input  logic [7:0]           rx_fifo_rdata,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_code,
    output logic [7:0]           cmd_len,
    output logic [MAX_LEN*8-1:0] cmd_payload,
    output logic                 chk_err,
    output logic                 len_err,
    output logic                 tmo_err,
    output logic [15:0]          err_cnt
);
    // Gap counter reads 0 the cycle after a byte lands; firing at TIMEOUT_CYC-2 puts
    // tmo_err exactly TIMEOUT_CYC cycles after that byte (requires TIMEOUT_CYC >= 2).
    localparam int              GAP_W    = $clog2(TIMEOUT_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {HUNT0, HUNT1, CMD, LEN, DATA, CHK} state_t;

    state_t               state, state_nxt;
    logic                 rd_vld;
    logic [GAP_W-1:0]     gap;
    logic [7:0]           idx;
    logic [7:0]           sum;
    logic [7:0]           wcode;
    logic [7:0]           wlen;
    logic [MAX_LEN*8-1:0] wbuf;
    logic                 good, chk_bad, len_bad, tmo_hit;

    assign rx_fifo_ren = !rst && ena && !rx_fifo_empty && !rd_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HUNT0;
            rd_vld <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= rx_fifo_ren;
        end
    end

    always_comb begin
        state_nxt = state;
        good      = 1'b0;
        chk_bad   = 1'b0;
        len_bad   = 1'b0;
        tmo_hit   = 1'b0;
        if (!ena) begin
            state_nxt = HUNT0;
        end else if (rd_vld) begin
            case (state)
                HUNT0: if (rx_fifo_rdata == HDR0) state_nxt = HUNT1;
                HUNT1: begin
                    if (rx_fifo_rdata == HDR1)      state_nxt = CMD;
                    else if (rx_fifo_rdata != HDR0) state_nxt = HUNT0;
                end
                CMD:   state_nxt = LEN;
                LEN: begin
                    if (rx_fifo_rdata > 8'(MAX_LEN)) begin
                        len_bad   = 1'b1;
                        state_nxt = HUNT0;
                    end else if (rx_fifo_rdata == 8'd0) begin
                        state_nxt = CHK;
                    end else begin
                        state_nxt = DATA;
                    end
                end
                DATA:  if (idx == wlen - 8'd1) state_nxt = CHK;
                CHK: begin
                    good      = (rx_fifo_rdata == sum);
                    chk_bad   = !good;
                    state_nxt = HUNT0;
                end
                default: state_nxt = HUNT0;
            endcase
        end else if (state != HUNT0 && gap == GAP_LAST) begin
            tmo_hit   = 1'b1;
            state_nxt = HUNT0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap <= '0;
            idx <= '0;
        end else begin
            if (!ena || rd_vld || state == HUNT0) gap <= '0;
            else                                  gap <= gap + GAP_W'(1);
            if (!ena)                           idx <= '0;
            else if (rd_vld && state == LEN)    idx <= '0;
            else if (rd_vld && state == DATA)   idx <= idx + 8'd1;
        end
    end

    // Working frame: only meaningful between CMD and CHK, so no reset needed.
    always_ff @(posedge clk) begin
        if (!ena) begin
            sum <= '0;
        end else if (rd_vld) begin
            case (state)
                CMD: begin
                    wcode <= rx_fifo_rdata;
                    sum   <= rx_fifo_rdata;
                end
                LEN: begin
                    wlen <= rx_fifo_rdata;
                    sum  <= sum + rx_fifo_rdata;
                end
                DATA: begin
                    sum <= sum + rx_fifo_rdata;
                    for (int i = 0; i < MAX_LEN; i++)
                        if (idx == 8'(i)) wbuf[8*i +: 8] <= rx_fifo_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid   <= 1'b0;
            chk_err     <= 1'b0;
            len_err     <= 1'b0;
            tmo_err     <= 1'b0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
        end else begin
            cmd_valid <= good;
            chk_err   <= chk_bad;
            len_err   <= len_bad;
            tmo_err   <= tmo_hit;
            if (good) begin
                cmd_code <= wcode;
                cmd_len  <= wlen;
                // Stale bytes from longer earlier frames must not leak above LEN.
                for (int i = 0; i < MAX_LEN; i++)
                    cmd_payload[8*i +: 8] <= (8'(i) < wlen) ? wbuf[8*i +: 8] : 8'h00;
            end
        end
    end

`ifdef CMD_RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if ((chk_err || len_err || tmo_err) && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed scoreboard bench for cmd_frame_rx: a byte-queue FIFO model feeds frames,
// expected strobes are queued as frames are sent and popped when the DUT pulses.
`timescale 1ns/1ps
module tb_cmd_frame_rx;
    localparam int MAX_LEN = 16;
    localparam int TMO     = 50;
    localparam int PW      = MAX_LEN * 8;
`ifdef CMD_RX_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ena, rx_fifo_empty, rx_fifo_ren;
    logic [7:0]    rx_fifo_rdata;
    logic          cmd_valid, chk_err, len_err, tmo_err;
    logic [7:0]    cmd_code, cmd_len;
    logic [PW-1:0] cmd_payload;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    cmd_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_ren(rx_fifo_ren), .rx_fifo_rdata(rx_fifo_rdata),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
        .chk_err(chk_err), .len_err(len_err), .tmo_err(tmo_err), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [3:0]    kind;   // {valid, chk, len, tmo}
        logic [7:0]    code;
        logic [7:0]    len;
        logic [PW-1:0] pl;
    } exp_t;

    exp_t          sb[$];
    logic [7:0]    fq[$];
    logic          pend_q;
    logic          prev_pend = 1'b0;
    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0, last_rdv = 0, b2b = 0, tmo_gap = -1;
    logic [7:0]    good_code = 8'h00, good_len = 8'h00;
    logic [PW-1:0] good_pl = '0;
    logic [PW-1:0] pl16;

    // A read strobe sampled at this edge means the FIFO must present its byte next cycle.
    always @(posedge clk) pend_q <= rx_fifo_ren;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, req);
            $error("%s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic monitor();
        logic [3:0] k;
        exp_t       e;
        k = {cmd_valid, chk_err, len_err, tmo_err};
        if (|k) begin
            if (sb.size() == 0) begin
                check("unexpected_event", PW'(k), PW'(0));
            end else begin
                e = sb.pop_front();
                check("event_kind",  PW'(k),        PW'(e.kind));
                check("cmd_code",    PW'(cmd_code), PW'(e.code));
                check("cmd_len",     PW'(cmd_len),  PW'(e.len));
                check("cmd_payload", cmd_payload,   e.pl);
                if (k == 4'b0001) tmo_gap = cyc - last_rdv;
                else              check("latency", PW'(cyc - last_rdv), PW'(1));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pend_q === 1'b1) begin
            last_rdv = cyc;
            if (fq.size() > 0) rx_fifo_rdata = fq.pop_front();
        end
        if (pend_q === 1'b1 && prev_pend === 1'b1) b2b++;
        prev_pend     = pend_q;
        rx_fifo_empty = (fq.size() == 0);
        #1;
        monitor();
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        rx_fifo_empty = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] l,
                              input logic [PW-1:0] p, input bit bad);
        logic [7:0] s;
        push(8'hEB); push(8'h90); push(c); push(l);
        s = c + l;
        for (int i = 0; i < int'(l); i++) begin
            push(p[8*i +: 8]);
            s = s + p[8*i +: 8];
        end
        push(bad ? s + 8'd1 : s);
    endtask

    task automatic exp_valid(input logic [7:0] c, input logic [7:0] l, input logic [PW-1:0] p);
        exp_t e;
        e.kind = 4'b1000; e.code = c; e.len = l; e.pl = p;
        sb.push_back(e);
        good_code = c; good_len = l; good_pl = p;
    endtask

    task automatic exp_err(input logic [3:0] k);
        exp_t e;
        e.kind = k; e.code = good_code; e.len = good_len; e.pl = good_pl;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", PW'(sb.size()), PW'(0));
        repeat (6) tick();
    endtask

    initial begin
        int n;
        rst = 1'b1; ena = 1'b0; rx_fifo_empty = 1'b1; rx_fifo_rdata = 8'h00;
        repeat (3) tick();
        check("rst_ctrl", PW'({rx_fifo_ren, cmd_valid, chk_err, len_err, tmo_err}), PW'(0));
        check("rst_code", PW'(cmd_code), PW'(0));
        check("rst_len",  PW'(cmd_len),  PW'(0));
        check("rst_payload", cmd_payload, '0);
        check("rst_err_cnt", PW'(err_cnt), PW'(0));
        rst = 1'b0; ena = 1'b1;
        tick();

        // Basic good frame with a continuously non-empty FIFO
        send_frame(8'h05, 8'h02, PW'(16'h2211), 1'b0);
        exp_valid(8'h05, 8'h02, PW'(16'h2211));
        drain(100);
        check("ren_back_to_back", PW'(b2b), PW'(0));

        // Checksum off by one: error pulse, outputs hold the previous frame
        send_frame(8'h05, 8'h02, PW'(16'h2211), 1'b1);
        exp_err(4'b0100);
        drain(100);
        check("err_cnt_chk", PW'(err_cnt), PW'(CNT_ON ? 1 : 0));

        // Garbage then a repeated HDR0 while waiting for HDR1; zero-length frame
        push(8'h00); push(8'hEB); push(8'hEB); push(8'h90); push(8'h07); push(8'h00); push(8'h07);
        exp_valid(8'h07, 8'h00, '0);
        drain(100);

        // LEN one above the maximum, then a good frame is still accepted
        push(8'hEB); push(8'h90); push(8'h01); push(8'(MAX_LEN + 1));
        exp_err(4'b0010);
        send_frame(8'h09, 8'h03, PW'(24'h030201), 1'b0);
        exp_valid(8'h09, 8'h03, PW'(24'h030201));
        drain(100);
        check("err_cnt_len", PW'(err_cnt), PW'(CNT_ON ? 2 : 0));

        // Full MAX_LEN payload
        for (int i = 0; i < MAX_LEN; i++) pl16[8*i +: 8] = 8'hA0 + 8'(i);
        send_frame(8'h0A, 8'(MAX_LEN), pl16, 1'b0);
        exp_valid(8'h0A, 8'(MAX_LEN), pl16);
        drain(150);

        // Inter-byte timeout after CMD, then recovery
        push(8'hEB); push(8'h90); push(8'h05);
        exp_err(4'b0001);
        drain(TMO + 60);
        check("tmo_gap", PW'(tmo_gap), PW'(TMO));
        send_frame(8'h05, 8'h02, PW'(16'h2211), 1'b0);
        exp_valid(8'h05, 8'h02, PW'(16'h2211));
        drain(100);
        check("err_cnt_tmo", PW'(err_cnt), PW'(CNT_ON ? 3 : 0));

        // Drop ena while the last partial-frame byte is landing, then resend
        push(8'hEB); push(8'h90); push(8'h05); push(8'h02); push(8'h11);
        n = 0;
        while (!(pend_q === 1'b1 && fq.size() == 0) && n < 100) begin
            tick();
            n++;
        end
        check("ena_window", PW'(n < 100), PW'(1));
        ena = 1'b0;
        send_frame(8'h0C, 8'h01, PW'(8'h55), 1'b0);
        repeat (4) tick();
        check("ren_ena_low", PW'(rx_fifo_ren), PW'(0));
        ena = 1'b1;
        exp_valid(8'h0C, 8'h01, PW'(8'h55));
        drain(100);

        // Asynchronous reset mid-frame clears everything at once
        push(8'hEB); push(8'h90); push(8'h05); push(8'h02);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("midrst_ctrl", PW'({rx_fifo_ren, cmd_valid, chk_err, len_err, tmo_err}), PW'(0));
        check("midrst_code", PW'(cmd_code), PW'(0));
        check("midrst_len",  PW'(cmd_len),  PW'(0));
        check("midrst_payload", cmd_payload, '0);
        check("midrst_err_cnt", PW'(err_cnt), PW'(0));
        fq.delete();
        rx_fifo_empty = 1'b1;
        good_code = 8'h00; good_len = 8'h00; good_pl = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send_frame(8'h0C, 8'h01, PW'(8'h55), 1'b0);
        exp_valid(8'h0C, 8'h01, PW'(8'h55));
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
